// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC, valid/ready imem requests, IF/ID register; zero-wait memory gives 1 instr/cycle.
// Backpressure: shouldStall freezes IF/ID; a word returning under stall is parked in holdBuffer (HOLD, no request).
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic        isJumpIndex,
  input  logic [25:0] jumpIndex,
  input  logic        isJumpRegister,
  input  logic [31:0] registerRsValue,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  output logic [31:0] instruction,
  output logic [31:0] pc_4,
  output logic        instructionValid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic        pending_q;
  logic [31:0] target_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  logic        accept;
  logic        fire;
  logic [31:0] word;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target_d;
  logic [31:0] pc_d;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = !shouldStall && (((state_q == FETCH) && imemReady) || (state_q == HOLD));
  assign word     = (state_q == HOLD) ? hold_q : imemData;
  // Jump/branch controls only mean something while ID holds a real instruction.
  assign fire     = !shouldStall && valid_q && shouldJumpOrBranch;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    target_d = pc4_q + br_off;
    if (isJumpRegister)   target_d = registerRsValue;
    else if (isJumpIndex) target_d = {pc4_q[31:28], jumpIndex, 2'b00};
    target_d[1:0] = 2'b00;
  end

  always_comb begin
    pc_d = pc_plus4;
    if (fire)           pc_d = target_d;
    else if (pending_q) pc_d = target_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      pc_q      <= RESET_PC;
      hold_q    <= 32'h0;
      pending_q <= 1'b0;
      target_q  <= 32'h0;
      instr_q   <= 32'h0;
      pc4_q     <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imemReady && shouldStall) begin
            hold_q  <= imemData;
            state_q <= HOLD;
            req_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (!shouldStall) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase

      // The delay slot is whatever is in flight when the redirect fires; the PC moves once it lands.
      if (accept) begin
        pc_q      <= pc_d;
        pending_q <= 1'b0;
      end else if (fire) begin
        pending_q <= 1'b1;
      end
      if (fire) target_q <= target_d;

      if (!shouldStall) begin
        if (accept) begin
          instr_q <= word;
          pc4_q   <= pc_plus4;
          valid_q <= 1'b1;
        end else begin
          instr_q <= 32'h0;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign imemRequest      = req_q;
  assign imemAddress      = {pc_q[31:2], 2'b00};
  assign instruction      = instr_q;
  assign pc_4             = pc4_q;
  assign instructionValid = valid_q;

endmodule
